// File: rtl/char_disp_ctrl_attr_if.sv
// ---------------------------------------------------------------------------
// char_disp_ctrl_attr_if
// Purpose : CPU-side bus of the attributed text-mode display controller.
//           Carries cell writes/reads, scroll control, clear-screen handshake
//           and cursor loading.
// Signals : we / w_adrs / char_code / attr_in  cell write {blink,inverse}
//           char_code_out                      cell read, 1-cycle latency
//           scroll_we / scroll_row             scroll shadow load
//           clr_req / clr_busy                 clear-screen start / status
//           cur_we / cur_x / cur_y             cursor load (optional feature)
// Modports: master = CPU / bus decoder side, slave = display controller side
// ---------------------------------------------------------------------------
interface char_disp_ctrl_attr_if;
    logic        we;
    logic [12:0] w_adrs;
    logic [7:0]  char_code;
    logic [1:0]  attr_in;
    logic [7:0]  char_code_out;
    logic        scroll_we;
    logic [5:0]  scroll_row;
    logic        clr_req;
    logic        clr_busy;
    logic        cur_we;
    logic [6:0]  cur_x;
    logic [5:0]  cur_y;

    modport master (
        output we, w_adrs, char_code, attr_in, scroll_we, scroll_row,
               clr_req, cur_we, cur_x, cur_y,
        input  char_code_out, clr_busy
    );

    modport slave (
        input  we, w_adrs, char_code, attr_in, scroll_we, scroll_row,
               clr_req, cur_we, cur_x, cur_y,
        output char_code_out, clr_busy
    );
endinterface

// File: rtl/char_disp_ctrl_attr.sv
// ---------------------------------------------------------------------------
// char_disp_ctrl_attr
// Purpose : Parametrised text-mode display controller with per-cell
//           attributes (inverse, blink), frame-synchronised hardware scroll,
//           a clear-screen engine and an optional blinking cursor.
//           Single clock domain (pixel_clk) shared by CPU port and pixels.
// Ports   : pixel_clk, reset (async, active-high)
//           iCoord_X / iCoord_Y   current pixel coordinate from VGA timing
//           iFrame_start          one-cycle pulse at start of each frame
//           re                    display enable (active region)
//           oRed / oGreen / oBlue registered pixel colour, 3-cycle latency
//           bus                   CPU bus (char_disp_ctrl_attr_if.slave)
// Config  : define CHAR_DISP_CURSOR_EN to build the cursor register; without
//           it cur_we/cur_x/cur_y are ignored and no cursor is drawn.
// ---------------------------------------------------------------------------
module char_disp_ctrl_attr #(
    parameter int         COLS         = 80,
    parameter int         ROWS         = 60,
    parameter int         BLINK_FRAMES = 32,
    parameter logic [7:0] CLR_CHAR     = 8'h20,
    parameter logic [9:0] ON_R         = 10'd0,
    parameter logic [9:0] ON_G         = 10'd0,
    parameter logic [9:0] ON_B         = 10'd0,
    parameter logic [9:0] OFF_R        = 10'd1023,
    parameter logic [9:0] OFF_G        = 10'd1023,
    parameter logic [9:0] OFF_B        = 10'd1023
) (
    input  logic                        pixel_clk,
    input  logic                        reset,
    input  logic [9:0]                  iCoord_X,
    input  logic [9:0]                  iCoord_Y,
    input  logic                        iFrame_start,
    input  logic                        re,
    output logic [9:0]                  oRed,
    output logic [9:0]                  oGreen,
    output logic [9:0]                  oBlue,
    char_disp_ctrl_attr_if.slave        bus
);
    // COLS may be 128, so its compare constant needs 8 bits
    localparam logic [7:0]    COLS_L     = 8'(COLS);
    localparam logic [6:0]    ROWS_L     = 7'(ROWS);
    localparam logic [6:0]    LAST_COL   = 7'(COLS - 1);
    localparam logic [5:0]    LAST_ROW   = 6'(ROWS - 1);
    localparam int            BW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    typedef enum logic {IDLE, CLEAR} clrState_t;

    // Each cell holds {char[7:0], blink, inverse}, addressed {row, col}
    logic [9:0]    r_ram [0:8191];

    clrState_t     r_state;
    logic          r_clrBusy;
    logic [5:0]    r_clrRow;
    logic [6:0]    r_clrCol;
    logic [7:0]    r_cpuRd;
    logic [5:0]    r_scrollShadow, r_scrollActive;
    logic [BW-1:0] r_blinkCnt;
    logic          r_blinkPhase;

    logic [9:0]    r_cell1;
    logic [2:0]    r_fx1, r_fy1, r_fx2;
    logic          r_vis1, r_cur1, r_vis2, r_cur2;
    logic [7:0]    r_glyph2;
    logic [1:0]    r_attr2;

    logic [6:0]    w_col, w_lrow, w_rowSum, w_physRow;
    logic          w_inRange, w_curMatch, w_cpuInRange, w_ramWe, w_pixOn;
    logic [12:0]   w_dispAddr, w_ramAddr;
    logic [9:0]    w_ramData;

    // Glyph rows: blank for space, a real 'A', every other code gets its own
    // code rotated left by the glyph row so each character is distinct.
    function automatic logic [7:0] fontRow(input logic [7:0] c, input logic [2:0] r);
        logic [15:0] rot;
        rot = {c, c} << r;
        if (c == 8'h20) return 8'h00;
        if (c == 8'h41) begin
            case (r)
                3'd0:    return 8'h18;
                3'd1:    return 8'h24;
                3'd4:    return 8'h7E;
                3'd7:    return 8'h00;
                default: return 8'h42;
            endcase
        end
        return rot[15:8];
    endfunction

    assign w_col      = iCoord_X[9:3];
    assign w_lrow     = iCoord_Y[9:3];
    assign w_inRange  = ({1'b0, w_col} < COLS_L) && (w_lrow < ROWS_L);
    // Scroll wrap needs only one subtract because both operands are < ROWS
    assign w_rowSum   = {1'b0, w_lrow[5:0]} + {1'b0, r_scrollActive};
    assign w_physRow  = (w_rowSum >= ROWS_L) ? (w_rowSum - ROWS_L) : w_rowSum;
    assign w_dispAddr = w_inRange ? {w_physRow[5:0], w_col} : 13'd0;

`ifdef CHAR_DISP_CURSOR_EN
    logic [6:0] r_curX;
    logic [5:0] r_curY;

    // Cursor position is in logical (scrolled) coordinates
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            r_curX <= '0;
            r_curY <= '0;
        end else if (bus.cur_we) begin
            r_curX <= bus.cur_x;
            r_curY <= bus.cur_y;
        end
    end
    assign w_curMatch = (w_col == r_curX) && (w_lrow == {1'b0, r_curY});
`else
    logic w_unusedCur;
    assign w_unusedCur = ^{bus.cur_we, bus.cur_x, bus.cur_y};
    assign w_curMatch  = 1'b0;
`endif

    // Scroll shadow takes effect only at frame start so a frame never tears;
    // the blink counter also advances once per frame.
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            r_scrollShadow <= '0;
            r_scrollActive <= '0;
            r_blinkCnt     <= '0;
            r_blinkPhase   <= 1'b0;
        end else begin
            if (bus.scroll_we)
                r_scrollShadow <= ({1'b0, bus.scroll_row} >= ROWS_L) ? 6'd0 : bus.scroll_row;
            if (iFrame_start) begin
                r_scrollActive <= r_scrollShadow;
                if (r_blinkCnt == BLINK_LAST) begin
                    r_blinkCnt   <= '0;
                    r_blinkPhase <= ~r_blinkPhase;
                end else begin
                    r_blinkCnt <= r_blinkCnt + 1'b1;
                end
            end
        end
    end

    // Clear engine sweeps every visible cell, one per cycle, row-major.
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_clrBusy <= 1'b0;
            r_clrRow  <= '0;
            r_clrCol  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.clr_req) begin
                        r_state   <= CLEAR;
                        r_clrBusy <= 1'b1;
                        r_clrRow  <= '0;
                        r_clrCol  <= '0;
                    end
                end
                CLEAR: begin
                    if (r_clrCol == LAST_COL) begin
                        r_clrCol <= '0;
                        if (r_clrRow == LAST_ROW) begin
                            r_state   <= IDLE;
                            r_clrBusy <= 1'b0;
                        end else begin
                            r_clrRow <= r_clrRow + 1'b1;
                        end
                    end else begin
                        r_clrCol <= r_clrCol + 1'b1;
                    end
                end
            endcase
        end
    end

    // The clear engine owns the write port while busy; CPU writes are dropped.
    assign w_cpuInRange = ({1'b0, bus.w_adrs[6:0]} < COLS_L) && ({1'b0, bus.w_adrs[12:7]} < ROWS_L);
    assign w_ramWe      = (r_state == CLEAR) || (bus.we && w_cpuInRange);
    assign w_ramAddr    = (r_state == CLEAR) ? {r_clrRow, r_clrCol} : bus.w_adrs;
    assign w_ramData    = (r_state == CLEAR) ? {CLR_CHAR, 2'b00} : {bus.char_code, bus.attr_in};

    always_ff @(posedge pixel_clk) begin
        if (w_ramWe)
            r_ram[w_ramAddr] <= w_ramData;
    end

    // Registered reads see the pre-write contents on a same-cycle write.
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset)
            r_cpuRd <= 8'd0;
        else
            r_cpuRd <= w_cpuInRange ? r_ram[bus.w_adrs][9:2] : 8'd0;
    end

    assign bus.char_code_out = r_cpuRd;
    assign bus.clr_busy      = r_clrBusy;

    // Three-stage pixel pipeline: cell read, font read, bit select + colour.
    assign w_pixOn = (r_glyph2[~r_fx2] ^ r_attr2[0] ^ (r_cur2 & r_blinkPhase))
                     & ~(r_attr2[1] & r_blinkPhase) & r_vis2;

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            r_cell1  <= '0;
            r_fx1    <= '0;
            r_fy1    <= '0;
            r_vis1   <= 1'b0;
            r_cur1   <= 1'b0;
            r_glyph2 <= '0;
            r_attr2  <= '0;
            r_fx2    <= '0;
            r_vis2   <= 1'b0;
            r_cur2   <= 1'b0;
            oRed     <= OFF_R;
            oGreen   <= OFF_G;
            oBlue    <= OFF_B;
        end else begin
            r_cell1  <= r_ram[w_dispAddr];
            r_fx1    <= iCoord_X[2:0];
            r_fy1    <= iCoord_Y[2:0];
            r_vis1   <= re & w_inRange;
            r_cur1   <= w_curMatch;
            r_glyph2 <= fontRow(r_cell1[9:2], r_fy1);
            r_attr2  <= r_cell1[1:0];
            r_fx2    <= r_fx1;
            r_vis2   <= r_vis1;
            r_cur2   <= r_cur1;
            oRed     <= w_pixOn ? ON_R : OFF_R;
            oGreen   <= w_pixOn ? ON_G : OFF_G;
            oBlue    <= w_pixOn ? ON_B : OFF_B;
        end
    end
endmodule

// File: tb/tb_char_disp_ctrl_attr.sv
// ---------------------------------------------------------------------------
// tb_char_disp_ctrl_attr
// Scoreboard bench: stimulus pushes expected pixel colours and cell reads
// into queues; a monitor pops and compares whenever the documented latency
// says an output is due. Expected values come from a behavioural model of
// the screen (cell arrays, scroll, frame count, cursor).
// ---------------------------------------------------------------------------
module tb_char_disp_ctrl_attr;
    localparam int         COLS  = 80;
    localparam int         ROWS  = 60;
    localparam int         BF    = 2;
    localparam logic [9:0] ON_V  = 10'd0;
    localparam logic [9:0] OFF_V = 10'd1023;
`ifdef CHAR_DISP_CURSOR_EN
    localparam bit CUR_EN = 1'b1;
`else
    localparam bit CUR_EN = 1'b0;
`endif

    logic       pixel_clk = 1'b0;
    logic       reset;
    logic [9:0] iCoord_X, iCoord_Y;
    logic       iFrame_start, re;
    logic [9:0] oRed, oGreen, oBlue;

    char_disp_ctrl_attr_if bus();

    char_disp_ctrl_attr #(.BLINK_FRAMES(BF)) dut (
        .pixel_clk   (pixel_clk),
        .reset       (reset),
        .iCoord_X    (iCoord_X),
        .iCoord_Y    (iCoord_Y),
        .iFrame_start(iFrame_start),
        .re          (re),
        .oRed        (oRed),
        .oGreen      (oGreen),
        .oBlue       (oBlue),
        .bus         (bus)
    );

    always #5 pixel_clk = ~pixel_clk;

    int compared   = 0;
    int mismatched = 0;

    bit       pixQ[$];
    bit [7:0] rdQ[$];
    logic     pixValid, rdValid;
    logic [2:0] pixPipe;
    logic     rdPipe;

    // Screen model
    bit [7:0] mChar [0:8191];
    bit [1:0] mAttr [0:8191];
    int mShadow, mActive, mFrames, mCurX, mCurY;
    int glyphA [0:7] = '{8'h18, 8'h24, 8'h42, 8'h42, 8'h7E, 8'h42, 8'h42, 8'h00};

    function automatic int refFont(int c, int r);
        if (c == 8'h41) return glyphA[r];
        if (c == 8'h20) return 0;
        return ((c << r) | (c >> (8 - r))) & 255;
    endfunction

    function automatic bit expPixel(int x, int y, bit reV);
        int col, lrow, idx, phase;
        bit g, cur;
        col  = x / 8;
        lrow = y / 8;
        if (!reV || col >= COLS || lrow >= ROWS) return 1'b0;
        idx   = ((lrow + mActive) % ROWS) * 128 + col;
        phase = (mFrames / BF) % 2;
        g     = ((refFont(mChar[idx], y % 8) >> (7 - x % 8)) & 1) != 0;
        cur   = CUR_EN && col == mCurX && lrow == mCurY && phase == 1;
        return (g ^ mAttr[idx][0] ^ cur) && !(mAttr[idx][1] && phase == 1);
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Delay lines carry the documented latencies (3 for pixels, 1 for reads)
    always @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            pixPipe <= '0;
            rdPipe  <= 1'b0;
        end else begin
            pixPipe <= {pixPipe[1:0], pixValid};
            rdPipe  <= rdValid;
        end
    end

    always @(negedge pixel_clk) begin
        bit       e;
        bit [7:0] r;
        if (!reset && pixPipe[2]) begin
            if (pixQ.size() == 0) checkOutput("pix_queue_underflow", 1, 0);
            else begin
                e = pixQ.pop_front();
                checkOutput("pixel_rgb", {oRed, oGreen, oBlue}, e ? {ON_V, ON_V, ON_V} : {OFF_V, OFF_V, OFF_V});
            end
        end
        if (!reset && rdPipe) begin
            if (rdQ.size() == 0) checkOutput("rd_queue_underflow", 1, 0);
            else begin
                r = rdQ.pop_front();
                checkOutput("char_code_out", bus.char_code_out, r);
            end
        end
    end

    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic idle(input int n);
        pixValid = 1'b0;
        rdValid  = 1'b0;
        re       = 1'b0;
        repeat (n) tick();
    endtask

    task automatic applyStimulus(input int x, input int y, input bit reV);
        iCoord_X = x[9:0];
        iCoord_Y = y[9:0];
        re       = reV;
        pixValid = 1'b1;
        pixQ.push_back(expPixel(x, y, reV));
        tick();
    endtask

    task automatic scanCell(input int lrow, input int col);
        for (int yy = 0; yy < 8; yy++)
            for (int xx = 0; xx < 8; xx++)
                applyStimulus(col * 8 + xx, lrow * 8 + yy, 1'b1);
        idle(4);
    endtask

    function automatic bit [7:0] expRead(int row, int col);
        if (row < ROWS && col < COLS) return mChar[row * 128 + col];
        return 8'h00;
    endfunction

    task automatic cpuWrite(input int row, input int col, input int ch, input int at);
        bus.we        = 1'b1;
        bus.w_adrs    = {row[5:0], col[6:0]};
        bus.char_code = ch[7:0];
        bus.attr_in   = at[1:0];
        rdValid       = 1'b1;
        rdQ.push_back(expRead(row, col));
        tick();
        bus.we  = 1'b0;
        rdValid = 1'b0;
        if (row < ROWS && col < COLS) begin
            mChar[row * 128 + col] = ch[7:0];
            mAttr[row * 128 + col] = at[1:0];
        end
    endtask

    task automatic cpuRead(input int row, input int col);
        bus.w_adrs = {row[5:0], col[6:0]};
        rdValid    = 1'b1;
        rdQ.push_back(expRead(row, col));
        tick();
        rdValid = 1'b0;
    endtask

    task automatic frameStart();
        iFrame_start = 1'b1;
        tick();
        iFrame_start = 1'b0;
        mActive = mShadow;
        mFrames++;
    endtask

    task automatic setScroll(input int v);
        bus.scroll_we  = 1'b1;
        bus.scroll_row = v[5:0];
        tick();
        bus.scroll_we = 1'b0;
        mShadow = (v >= ROWS) ? 0 : v;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int  busyCount;
        bit  done;
        reset = 1'b1; iCoord_X = '0; iCoord_Y = '0; iFrame_start = 1'b0; re = 1'b0;
        pixValid = 1'b0; rdValid = 1'b0;
        bus.we = 1'b0; bus.w_adrs = '0; bus.char_code = '0; bus.attr_in = '0;
        bus.scroll_we = 1'b0; bus.scroll_row = '0; bus.clr_req = 1'b0;
        bus.cur_we = 1'b0; bus.cur_x = '0; bus.cur_y = '0;
        mShadow = 0; mActive = 0; mFrames = 0; mCurX = 0; mCurY = 0;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge pixel_clk);
        checkOutput("reset_oRed", oRed, OFF_V);
        checkOutput("reset_oGreen", oGreen, OFF_V);
        checkOutput("reset_oBlue", oBlue, OFF_V);
        checkOutput("reset_char_code_out", bus.char_code_out, 0);
        checkOutput("reset_clr_busy", bus.clr_busy, 0);
        tick();

        // Clear screen; a CPU write and a second clr_req mid-clear must be ignored
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        busyCount = 0;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 6000 && !done; i++) begin
                    @(negedge pixel_clk);
                    if (bus.clr_busy) busyCount++;
                    else if (busyCount > 0) done = 1'b1;
                end
            end
            begin
                repeat (100) tick();
                bus.we = 1'b1; bus.w_adrs = {6'd0, 7'd3}; bus.char_code = 8'h5A;
                bus.attr_in = 2'b11; bus.clr_req = 1'b1;
                tick();
                bus.we = 1'b0; bus.clr_req = 1'b0;
            end
        join
        checkOutput("clr_busy_fell", done, 1);
        checkOutput("clr_busy_cycles", busyCount, ROWS * COLS);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                mChar[r * 128 + c] = 8'h20;
                mAttr[r * 128 + c] = 2'b00;
            end
        tick();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                cpuRead(r, c);
        idle(2);

        // Out-of-range writes dropped, reads return 0; last valid cell kept
        cpuWrite(0, 100, 8'h58, 0);
        cpuWrite(62, 5, 8'h58, 0);
        cpuWrite(59, 79, 8'h51, 0);
        cpuRead(0, 100);
        cpuRead(62, 5);
        cpuRead(59, 79);
        idle(2);

        // Plain and inverse glyphs
        cpuWrite(0, 0, 8'h41, 0);
        scanCell(0, 0);
        cpuWrite(1, 2, 8'h41, 1);
        scanCell(1, 2);
        scanCell(0, 1);

        // Same-cycle write and display read of one cell: display sees old data
        cpuWrite(2, 5, 8'h41, 0);
        idle(2);
        bus.we = 1'b1; bus.w_adrs = {6'd2, 7'd5}; bus.char_code = 8'h42; bus.attr_in = 2'b00;
        rdValid = 1'b1;
        rdQ.push_back(expRead(2, 5));
        applyStimulus(5 * 8, 2 * 8 + 1, 1'b1);
        bus.we = 1'b0; rdValid = 1'b0;
        mChar[2 * 128 + 5] = 8'h42;
        idle(4);
        scanCell(2, 5);

        // Scroll: shadow only applied at frame start, wrap and clamp
        cpuWrite(5, 0, 8'h35, 0);
        setScroll(5);
        scanCell(0, 0);
        frameStart();
        scanCell(0, 0);
        setScroll(59);
        frameStart();
        scanCell(1, 0);
        scanCell(0, 79);
        setScroll(63);
        frameStart();
        scanCell(0, 0);

        // Blink, and blink combined with inverse, across several frames
        cpuWrite(3, 3, 8'h41, 2);
        cpuWrite(3, 4, 8'h41, 3);
        for (int f = 0; f < 6; f++) begin
            scanCell(3, 3);
            scanCell(3, 4);
            frameStart();
        end

        // Cursor at column 3, row 4
        cpuWrite(4, 3, 8'h41, 0);
        bus.cur_we = 1'b1; bus.cur_x = 7'd3; bus.cur_y = 6'd4;
        tick();
        bus.cur_we = 1'b0;
        if (CUR_EN) begin
            mCurX = 3;
            mCurY = 4;
        end
        for (int f = 0; f < 4; f++) begin
            scanCell(4, 3);
            frameStart();
        end

        // Random writes and random pixels under random scroll
        for (int i = 0; i < 20; i++)
            cpuWrite($urandom_range(0, 63), $urandom_range(0, 127), $urandom_range(0, 255), $urandom_range(0, 3));
        idle(2);
        for (int b = 0; b < 4; b++) begin
            setScroll($urandom_range(0, 63));
            frameStart();
            for (int i = 0; i < 100; i++)
                applyStimulus($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 3) != 0);
            idle(4);
        end
        idle(4);
        checkOutput("pix_queue_empty", pixQ.size(), 0);
        checkOutput("rd_queue_empty", rdQ.size(), 0);

        // Reset during a clear: engine stops at once, RAM keeps partial result
        cpuWrite(0, 0, 8'h41, 1);
        cpuWrite(59, 79, 8'h51, 0);
        idle(2);
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        repeat (50) tick();
        reset = 1'b1;
        #1;
        checkOutput("midclear_reset_busy", bus.clr_busy, 0);
        checkOutput("midclear_reset_oRed", oRed, OFF_V);
        tick();
        reset = 1'b0;
        mShadow = 0; mActive = 0; mFrames = 0; mCurX = 0; mCurY = 0;
        mChar[0] = 8'h20;
        mAttr[0] = 2'b00;
        tick();
        cpuRead(0, 0);
        cpuRead(59, 79);
        idle(2);
        scanCell(0, 0);
        idle(4);
        checkOutput("final_pix_queue_empty", pixQ.size(), 0);
        checkOutput("final_rd_queue_empty", rdQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
